line_engine: RTL and testbench

LINE_ENGINE -- requirements
Module: line_engine

---
 rtl/line_pkg.sv | 13 +
 rtl/line_setup.sv | 51 +++++
 rtl/line_engine.sv | 159 +++++++++++++++
 tb/tb_line_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared constants and state encoding for the Bresenham line engine.
package line_pkg;
  localparam int FB_WIDTH  = 1024;
  localparam int FB_HEIGHT = 768;
  localparam int COORD_W   = 10;
  localparam int ERR_W     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_e;
endpackage

// File: rtl/line_setup.sv
// Combinational line setup: octant fold (steep swap), endpoint ordering and
// the deltas/initial error consumed by the stepping datapath.
module line_setup
  import line_pkg::*;
(
  input  logic [COORD_W-1:0]      x0,
  input  logic [COORD_W-1:0]      y0,
  input  logic [COORD_W-1:0]      x1,
  input  logic [COORD_W-1:0]      y1,
  output logic                    steep,
  output logic [COORD_W-1:0]      sx0,
  output logic [COORD_W-1:0]      sy0,
  output logic [COORD_W-1:0]      len,
  output logic signed [ERR_W-1:0] dx,
  output logic signed [ERR_W-1:0] dy,
  output logic signed [ERR_W-1:0] err0,
  output logic                    ystep_neg
);
  function automatic logic signed [ERR_W-1:0] ext(input logic [COORD_W-1:0] v);
    return $signed({{(ERR_W-COORD_W){1'b0}}, v});
  endfunction

  function automatic logic signed [ERR_W-1:0] abs_s(input logic signed [ERR_W-1:0] v);
    return v[ERR_W-1] ? -v : v;
  endfunction

  logic signed [ERR_W-1:0] ddx, ddy, dyr;
  logic [COORD_W-1:0]      a0, b0, a1, b1, pa1, pb1;

  always_comb begin
    ddx   = ext(x1) - ext(x0);
    ddy   = ext(y1) - ext(y0);
    steep = abs_s(ddy) > abs_s(ddx);
    // a is the stepping axis, b the dependent axis
    a0 = steep ? y0 : x0;
    b0 = steep ? x0 : y0;
    a1 = steep ? y1 : x1;
    b1 = steep ? x1 : y1;
    if (a0 > a1) begin
      sx0 = a1; sy0 = b1; pa1 = a0; pb1 = b0;
    end else begin
      sx0 = a0; sy0 = b0; pa1 = a1; pb1 = b1;
    end
    dx        = ext(pa1) - ext(sx0);
    dyr       = ext(pb1) - ext(sy0);
    dy        = abs_s(dyr);
    ystep_neg = dyr[ERR_W-1];
    err0      = (-dx) >>> 1;
    len       = pa1 - sx0;
  end
endmodule

// File: rtl/line_engine.sv
// Bresenham line engine: one pixel per cycle into the frame-buffer write port,
// rows at or below FB_HEIGHT are clipped without changing timing.
module line_engine
  import line_pkg::*;
#(
  parameter int mem_width      = 1,
  parameter int mem_depth      = 786432,
  parameter int mem_addr_width = $clog2(mem_depth)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [COORD_W-1:0]        x0,
  input  logic [COORD_W-1:0]        x1,
  input  logic [COORD_W-1:0]        y0,
  input  logic [COORD_W-1:0]        y1,
  input  logic [mem_width-1:0]      color,
  output logic                      ready,
  output logic                      XL_wr_en,
  output logic [mem_width-1:0]      XL_wr_data,
  output logic [mem_addr_width-1:0] XL_wr_addr
);
  localparam logic [COORD_W-1:0] ROW_LIMIT = COORD_W'(FB_HEIGHT);

  state_e state, state_nxt;

  logic [COORD_W-1:0]   cap_x0_p0, cap_y0_p0, cap_x1_p0, cap_y1_p0;
  logic [mem_width-1:0] cap_color_p0;

  logic                    steep_s, ystep_neg_s;
  logic [COORD_W-1:0]      sx0_s, sy0_s, len_s;
  logic signed [ERR_W-1:0] dx_s, dy_s, err0_s;

  logic                    steep_p1, ystep_neg_p1;
  logic [COORD_W-1:0]      cur_x_p1, cur_y_p1, cnt_p1;
  logic signed [ERR_W-1:0] dx_p1, dy_p1, err_p1;

  logic signed [ERR_W-1:0] err_inc, err_nxt;
  logic [COORD_W-1:0]      x_nxt, y_nxt;
  logic [2*COORD_W-1:0]    rc_first, rc_next;

  function automatic logic [2*COORD_W-1:0] pixel_rc(input logic steep,
                                                   input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return steep ? {a, b} : {b, a};
  endfunction

  function automatic logic visible(input logic [2*COORD_W-1:0] rc);
    return rc[2*COORD_W-1:COORD_W] < ROW_LIMIT;
  endfunction

  line_setup u_setup (
    .x0        (cap_x0_p0),
    .y0        (cap_y0_p0),
    .x1        (cap_x1_p0),
    .y1        (cap_y1_p0),
    .steep     (steep_s),
    .sx0       (sx0_s),
    .sy0       (sy0_s),
    .len       (len_s),
    .dx        (dx_s),
    .dy        (dy_s),
    .err0      (err0_s),
    .ystep_neg (ystep_neg_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = DRAW;
      DRAW:    if (cnt_p1 == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_comb begin
    err_inc = err_p1 + dy_p1;
    x_nxt   = cur_x_p1 + COORD_W'(1);
    y_nxt   = cur_y_p1;
    err_nxt = err_inc;
    if (!err_inc[ERR_W-1]) begin
      y_nxt   = ystep_neg_p1 ? cur_y_p1 - COORD_W'(1) : cur_y_p1 + COORD_W'(1);
      err_nxt = err_inc - dx_p1;
    end
    rc_first = pixel_rc(steep_s, sx0_s, sy0_s);
    rc_next  = pixel_rc(steep_p1, x_nxt, y_nxt);
  end

  // p0: endpoint capture in IDLE; p1: stepping state, loaded in SETUP, advanced in DRAW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_x0_p0    <= '0;
      cap_y0_p0    <= '0;
      cap_x1_p0    <= '0;
      cap_y1_p0    <= '0;
      cap_color_p0 <= '0;
      steep_p1     <= 1'b0;
      ystep_neg_p1 <= 1'b0;
      cur_x_p1     <= '0;
      cur_y_p1     <= '0;
      cnt_p1       <= '0;
      dx_p1        <= '0;
      dy_p1        <= '0;
      err_p1       <= '0;
      XL_wr_en     <= 1'b0;
      XL_wr_addr   <= '0;
      XL_wr_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          XL_wr_en <= 1'b0;
          if (start) begin
            cap_x0_p0    <= x0;
            cap_y0_p0    <= y0;
            cap_x1_p0    <= x1;
            cap_y1_p0    <= y1;
            cap_color_p0 <= color;
          end
        end
        SETUP: begin
          steep_p1     <= steep_s;
          ystep_neg_p1 <= ystep_neg_s;
          cur_x_p1     <= sx0_s;
          cur_y_p1     <= sy0_s;
          cnt_p1       <= len_s;
          dx_p1        <= dx_s;
          dy_p1        <= dy_s;
          err_p1       <= err0_s;
          XL_wr_en     <= visible(rc_first);
          XL_wr_addr   <= mem_addr_width'(rc_first);
          XL_wr_data   <= cap_color_p0;
        end
        DRAW: begin
          if (cnt_p1 == '0) begin
            XL_wr_en <= 1'b0;
          end else begin
            cur_x_p1   <= x_nxt;
            cur_y_p1   <= y_nxt;
            err_p1     <= err_nxt;
            cnt_p1     <= cnt_p1 - COORD_W'(1);
            XL_wr_en   <= visible(rc_next);
            XL_wr_addr <= mem_addr_width'(rc_next);
          end
        end
        default: XL_wr_en <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_line_engine.sv
// Bench for line_engine: directed corner lines plus random lines checked
// cycle-by-cycle against a closed-form line model.
module tb_line_engine;
  localparam int MW = 1;
  localparam int MD = 786432;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [MW-1:0] color = '0;
  logic          ready, wr_en;
  logic [MW-1:0] wr_data;
  logic [AW-1:0] wr_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_engine #(.mem_width(MW), .mem_depth(MD), .mem_addr_width(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .color      (color),
    .ready      (ready),
    .XL_wr_en   (wr_en),
    .XL_wr_data (wr_data),
    .XL_wr_addr (wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int ex_row[$];
  int ex_col[$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Pixel k lies b0 + s*floor((k*dy - ceil(dx/2) + dx)/dx) along the minor axis.
  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
    int a0, b0, a1, b1, t, dx, dy, c, s, m;
    bit steep;
    ex_row.delete();
    ex_col.delete();
    steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (steep) begin a0 = ay0; b0 = ax0; a1 = ay1; b1 = ax1; end
    else       begin a0 = ax0; b0 = ay0; a1 = ax1; b1 = ay1; end
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    dx = a1 - a0;
    dy = iabs(b1 - b0);
    s  = (b1 >= b0) ? 1 : -1;
    c  = (dx + 1) / 2;
    for (int k = 0; k <= dx; k++) begin
      m = (dx == 0) ? 0 : (k * dy - c + dx) / dx;
      if (steep) begin ex_row.push_back(a0 + k);  ex_col.push_back(b0 + s * m); end
      else       begin ex_row.push_back(b0 + s * m); ex_col.push_back(a0 + k); end
    end
  endtask

  task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                      input logic [MW-1:0] col, input string nm,
                      input int glitch_at, input int rst_at);
    int n, seen, vis, w;
    bit v;
    model(ax0, ay0, ax1, ay1);
    n = ex_row.size();
    w = 0;
    while (!ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready_before"}, ready, 1);
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    color = col;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    color = ~col;
    x0 = 10'($urandom); y0 = 10'($urandom); x1 = 10'($urandom); y1 = 10'($urandom);
    @(negedge clk);
    chk({nm, "_setup_en"}, wr_en, 0);
    chk({nm, "_setup_ready"}, ready, 0);
    seen = 0;
    vis = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v = ex_row[k] < 768;
      chk({nm, "_en"}, wr_en, v);
      chk({nm, "_busy"}, ready, 0);
      if (v) begin
        vis++;
        chk({nm, "_addr"}, wr_addr, ex_row[k] * 1024 + ex_col[k]);
        chk({nm, "_data"}, wr_data, col);
      end
      if (wr_en) seen++;
      start = (k == glitch_at);
      if (start) begin
        x0 = 10'($urandom); y0 = 10'($urandom); x1 = 10'($urandom); y1 = 10'($urandom);
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_en"}, wr_en, 0);
        chk({nm, "_rst_ready"}, ready, 1);
        chk({nm, "_rst_addr"}, wr_addr, 0);
        chk({nm, "_rst_data"}, wr_data, 0);
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_done_ready"}, ready, 1);
    chk({nm, "_done_en"}, wr_en, 0);
    chk({nm, "_count"}, seen, vis);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    int ax0, ay0, ax1, ay1;
    color = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_en", wr_en, 0);
    chk("reset_addr", wr_addr, 0);
    chk("reset_data", wr_data, 0);
    rst_n = 1'b1;

    draw(0, 0, 3, 0, 1'b1, "horiz", -1, -1);
    draw(2, 5, 0, 0, 1'b1, "rev_steep", -1, -1);
    draw(10, 10, 10, 10, 1'b1, "point", -1, -1);
    draw(0, 766, 0, 769, 1'b1, "clip", -1, -1);
    draw(0, 0, 100, 0, 1'b0, "ignore_start", 50, -1);
    draw(0, 0, 50, 50, 1'b1, "abort", -1, 4);

    quiet = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (wr_en) quiet++;
    end
    chk("post_abort_writes", quiet, 0);
    chk("post_abort_ready", ready, 1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    draw(5, 700, 20, 780, 1'b1, "first_after_rst", -1, -1);

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        ax0 = $urandom_range(0, 1023); ay0 = $urandom_range(0, 1023);
        ax1 = $urandom_range(0, 1023); ay1 = $urandom_range(0, 1023);
      end else begin
        ax0 = $urandom_range(0, 1023); ay0 = $urandom_range(740, 800);
        ax1 = (ax0 + $urandom_range(0, 40)) % 1024;
        ay1 = $urandom_range(740, 800);
      end
      draw(ax0, ay0, ax1, ay1, MW'($urandom), "rand", -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
